// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Ports:
//   requester 0/1 : req, lock, we, addr, wdata -> arbiter; gnt, rvalid <- arbiter
//   shared        : rdata (qualified by rvalid0/rvalid1)
//   memory side   : mem_address_output, mem_data_output, mem_write -> memory;
//                   mem_data_input <- memory (valid the cycle after the address)
// Modports: slave = arbiter view, master = requester/memory environment view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic                  lock0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;

    logic                  req1;
    logic                  lock1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;

    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] mem_address_output;
    logic [DATA_WIDTH-1:0] mem_data_output;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_data_input;

    modport slave (
        input  req0, lock0, we0, addr0, wdata0,
        input  req1, lock1, we1, addr1, wdata1,
        input  mem_data_input,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output mem_address_output, mem_data_output, mem_write
    );

    modport master (
        output req0, lock0, we0, addr0, wdata0,
        output req1, lock1, we1, addr1, wdata1,
        output mem_data_input,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  mem_address_output, mem_data_output, mem_write
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory, with a
// bus lock for atomic multi-cycle sequences. Grant and memory access happen
// in the same cycle; read data returns one cycle later on the shared rdata.
// Ports:
//   clk           system clock, rising edge
//   async_nreset  asynchronous active-low reset
//   bus           mem_bus_arbiter_if.slave (requester and memory signals)
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               async_nreset,
    mem_bus_arbiter_if.slave   bus
);

    logic last_gnt;
    logic lock_owner_valid;
    logic lock_owner;
    logic pend_rd0;
    logic pend_rd1;

    logic any_gnt;
    logic win;
    logic lock_hold;
    logic win_we;
    logic win_lock;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // Winner selection. The lock only holds while its owner keeps requesting;
    // once the owner drops req, normal arbitration takes over in that cycle.
    always_comb begin
        lock_hold = lock_owner_valid && (lock_owner ? bus.req1 : bus.req0);
        any_gnt   = 1'b0;
        win       = 1'b0;
        if (lock_hold) begin
            any_gnt = 1'b1;
            win     = lock_owner;
        end else if (bus.req0 && bus.req1) begin
            any_gnt = 1'b1;
            win     = ~last_gnt;
        end else if (bus.req0) begin
            any_gnt = 1'b1;
            win     = 1'b0;
        end else if (bus.req1) begin
            any_gnt = 1'b1;
            win     = 1'b1;
        end
        // Outputs must stay quiet while reset is held, even with requests up.
        if (!async_nreset) begin
            any_gnt = 1'b0;
        end
    end

    always_comb begin
        win_we    = win ? bus.we1    : bus.we0;
        win_lock  = win ? bus.lock1  : bus.lock0;
        win_addr  = win ? bus.addr1  : bus.addr0;
        win_wdata = win ? bus.wdata1 : bus.wdata0;

        bus.gnt0               = any_gnt && !win;
        bus.gnt1               = any_gnt && win;
        bus.mem_address_output = any_gnt ? win_addr : '0;
        bus.mem_write          = any_gnt && win_we;
        bus.mem_data_output    = (any_gnt && win_we) ? win_wdata : '0;

        bus.rvalid0 = pend_rd0;
        bus.rvalid1 = pend_rd1;
        bus.rdata   = (pend_rd0 || pend_rd1) ? bus.mem_data_input : '0;
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            last_gnt         <= 1'b1;
            lock_owner_valid <= 1'b0;
            lock_owner       <= 1'b0;
            pend_rd0         <= 1'b0;
            pend_rd1         <= 1'b0;
        end else begin
            pend_rd0 <= bus.gnt0 && !bus.we0;
            pend_rd1 <= bus.gnt1 && !bus.we1;
            if (any_gnt) begin
                last_gnt <= win;
                if (win_lock) begin
                    lock_owner       <= win;
                    lock_owner_valid <= 1'b1;
                end else begin
                    lock_owner_valid <= 1'b0;
                end
            end else begin
                // No grant means the owner (if any) has dropped req: release.
                lock_owner_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic async_nreset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mem_bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    mem_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Simple synchronous memory: data for an address appears the next cycle.
    logic [7:0] mem [256];
    logic [7:0] mem_q = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address_output] <= bus.mem_data_output;
        mem_q <= mem[bus.mem_address_output];
    end
    assign bus.mem_data_input = mem_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.lock0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.lock1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    endtask

    task automatic do_reset();
        async_nreset = 0;
        tick();
        async_nreset = 1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        idle_inputs();

        // Reset: requests up but outputs must stay quiet.
        bus.req0 = 1; bus.addr0 = 8'h33; bus.we0 = 1; bus.wdata0 = 8'hFF;
        #2;
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_addr", bus.mem_address_output, 0);
        chk("rst_wdata", bus.mem_data_output, 0);
        idle_inputs();
        do_reset();

        // 1: read by requester 0.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
        #1;
        chk("t1_gnt0", bus.gnt0, 1);
        chk("t1_gnt1", bus.gnt1, 0);
        chk("t1_addr", bus.mem_address_output, 8'h10);
        chk("t1_we", bus.mem_write, 0);
        tick();
        bus.req0 = 0;
        #1;
        chk("t1_rvalid0", bus.rvalid0, 1);
        chk("t1_rvalid1", bus.rvalid1, 0);
        chk("t1_rdata", bus.rdata, 8'h5A);

        // 2: write by requester 1.
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h20; bus.wdata1 = 8'hC3;
        #1;
        chk("t2_gnt1", bus.gnt1, 1);
        chk("t2_gnt0", bus.gnt0, 0);
        chk("t2_we", bus.mem_write, 1);
        chk("t2_addr", bus.mem_address_output, 8'h20);
        chk("t2_wdata", bus.mem_data_output, 8'hC3);
        tick();
        idle_inputs();
        #1;
        chk("t2_rvalid0", bus.rvalid0, 0);
        chk("t2_rvalid1", bus.rvalid1, 0);
        chk("t2_rdata", bus.rdata, 0);

        // 3: both reading continuously from reset, grants alternate 0,1,0,...
        tick();
        do_reset();
        bus.req0 = 1; bus.addr0 = 8'h10;
        bus.req1 = 1; bus.addr1 = 8'h20;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t3_gnt0_%0d", i), bus.gnt0, (i % 2 == 0));
            chk($sformatf("t3_gnt1_%0d", i), bus.gnt1, (i % 2 == 1));
            chk($sformatf("t3_mwe_%0d", i), bus.mem_write, 0);
            tick();
            chk($sformatf("t3_rv0_%0d", i), bus.rvalid0, (i % 2 == 0));
            chk($sformatf("t3_rv1_%0d", i), bus.rvalid1, (i % 2 == 1));
            chk($sformatf("t3_rdata_%0d", i), bus.rdata, (i % 2 == 0) ? 8'h5A : 8'hC3);
        end

        // 4: lock held by requester 0 for 3 cycles against a waiting requester 1.
        bus.lock0 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_gnt0_%0d", i), bus.gnt0, 1);
            chk($sformatf("t4_gnt1_%0d", i), bus.gnt1, 0);
            tick();
        end
        bus.req0 = 0; bus.lock0 = 0;
        #1;
        chk("t4_release_gnt1", bus.gnt1, 1);
        chk("t4_release_gnt0", bus.gnt0, 0);
        tick();
        idle_inputs();
        tick();

        // 5: reset lands between a requester-1 read grant and its data return.
        bus.req0 = 1; bus.addr0 = 8'h10;
        #1;
        chk("t5_pre_gnt0", bus.gnt0, 1);
        tick();
        bus.req0 = 0;
        bus.req1 = 1; bus.addr1 = 8'h20;
        #1;
        chk("t5_gnt1", bus.gnt1, 1);
        async_nreset = 0;
        #1;
        chk("t5_rst_gnt1", bus.gnt1, 0);
        tick();
        chk("t5_rvalid1", bus.rvalid1, 0);
        chk("t5_rdata", bus.rdata, 0);
        async_nreset = 1;
        bus.req0 = 1;
        #1;
        chk("t5_tie_gnt0", bus.gnt0, 1);
        chk("t5_tie_gnt1", bus.gnt1, 0);
        chk("t5_rvalid1_after", bus.rvalid1, 0);
        tick();
        idle_inputs();
        tick();

        // 6: idle bus.
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t6_gnt0_%0d", i), bus.gnt0, 0);
            chk($sformatf("t6_gnt1_%0d", i), bus.gnt1, 0);
            chk($sformatf("t6_we_%0d", i), bus.mem_write, 0);
            chk($sformatf("t6_addr_%0d", i), bus.mem_address_output, 0);
            chk($sformatf("t6_rdata_%0d", i), bus.rdata, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter for the single-port 8-bit data memory. Requester 0 is the CPU fetch/operand port; requester 1 is the DMA/IO port. The arbiter grants one access per cycle with round-robin fairness and supports a lock for atomic multi-cycle sequences. It drives the memory address, data and write lines and returns read data with fixed one-cycle latency.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 8, memory data width

Ports:
clk  input  1  system clock, rising edge
async_nreset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 access request, level
lock0  input  1  requester 0 holds bus after current grant
we0  input  1  requester 0 write enable (1 = write)
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
gnt0  output  1  requester 0 access performed this cycle
rvalid0  output  1  read data valid for requester 0
req1, lock1, we1, addr1, wdata1  input  1/1/1/ADDR_WIDTH/DATA_WIDTH  requester 1, same meaning
gnt1  output  1  requester 1 access performed this cycle
rvalid1  output  1  read data valid for requester 1
rdata  output  DATA_WIDTH  read data, shared; qualified by rvalid0/rvalid1
mem_address_output  output  ADDR_WIDTH  memory address
mem_data_output  output  DATA_WIDTH  memory write data
mem_write  output  1  memory write strobe
mem_data_input  input  DATA_WIDTH  memory read data, valid the cycle after the address

Behaviour:
- Registers: last_gnt (1 bit), lock_owner_valid, lock_owner (1 bit), pend_rd0, pend_rd1.
- Reset values: last_gnt=1 (requester 0 wins the first tie), lock cleared, pend_rd*=0.
- While reset is asserted: gnt0=gnt1=0, mem_write=0, mem_address_output=0, mem_data_output=0, rvalid*=0.
- Arbitration is combinational within the cycle. The grant and the memory access occur in the same cycle.
- Winner selection, in priority order:
  - Lock active and owner's req high: the owner wins. The other requester is blocked even if requesting.
  - Lock active and owner's req low: the lock is released this cycle and normal arbitration applies.
  - Only one req high: that requester wins.
  - Both req high: the requester != last_gnt wins (round-robin).
  - No req: no grant. Memory outputs are 0 and mem_write=0.
- Winner's addr drives mem_address_output. If we=1: mem_data_output=wdata and mem_write=1. If we=0: mem_data_output=0 and mem_write=0.
- On any grant to X:
  - last_gnt<=X.
  - If lockX=1: lock_owner<=X, lock_owner_valid<=1.
  - If lockX=0: lock_owner_valid<=0.
- Read return:
  - Granted read by X sets pend_rdX<=1 for exactly one cycle.
  - Next cycle: rvalidX=1 and rdata=mem_data_input.
  - When no rvalid is high, rdata=0.
  - Back-to-back reads are supported. A grant and an rvalid may coincide in the same cycle for the same or different requesters.
- Write: no rvalid. The write completes in the grant cycle.
- Requester protocol:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Drop req the cycle after gnt unless another access is wanted.
  - Changing inputs while ungranted is legal; the arbiter is stateless w.r.t. ungranted requests.
- Fairness bound: with both requesters continuously requesting and no locks, grants strictly alternate. The maximum wait is 1 cycle.
- Lock starvation is not bounded by the arbiter. Software limits lock duration.
- Reset mid-operation: pending rvalid is discarded and the lock is released; arbitration restarts with requester 0 priority.
- No X propagation: all outputs are defined every cycle.

Test Plan:
1. Reset, then req0 read addr=0x10 with mem returning 0x5A -> gnt0=1 in cycle 0, mem_address_output=0x10, mem_write=0; cycle 1 rvalid0=1, rdata=0x5A, rvalid1=0.
2. req1 write addr=0x20 wdata=0xC3 -> gnt1=1, mem_write=1, mem_address_output=0x20, mem_data_output=0xC3; no rvalid in the following cycle.
3. req0 and req1 held high for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; each rvalid follows its read grant by one cycle.
4. req0+lock0 held 3 cycles while req1 high -> gnt0 for 3 cycles, gnt1=0; lock0 and req0 dropped -> gnt1 the next cycle.
5. Read granted to requester 1, async_nreset pulsed low before the next edge -> rvalid1 never asserts; the first post-reset tie goes to requester 0.
6. No requests for 4 cycles -> gnt*=0, mem_write=0, mem_address_output=0, rdata=0 throughout.
